// File: rtl/trivium_ks_packer.sv
// Packs the serial Trivium keystream into W-bit words and XORs them with pt words.
// Define TRIV_PACK_LSBFIRST_EN to place the first received keystream bit in bit 0.
module trivium_ks_packer #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ks_bit,
  input  logic         ks_vld,
  output logic         ks_stall,
  input  logic [W-1:0] pt_data,
  input  logic         pt_vld,
  output logic         pt_rdy,
  output logic [W-1:0] ct_data,
  output logic         ct_vld,
  input  logic         ct_rdy,
  input  logic         flush,
  output logic         ovf
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [W-1:0]     sr;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     hold_word;
  logic             hold_full;

  logic             sr_full;
  logic             stall_core;
  logic             bit_acc;
  logic             pt_hs;
  logic             xfer;
  logic [W-1:0]     sr_next;

  // stall_core depends only on registered state; flush merely widens it.
  assign sr_full    = (cnt == CNT_FULL);
  assign stall_core = sr_full && hold_full;
  assign ks_stall   = stall_core || flush;
  assign pt_rdy     = !flush && hold_full && (!ct_vld || ct_rdy);
  assign bit_acc    = ks_vld && !ks_stall;
  assign pt_hs      = pt_vld && pt_rdy;
  assign xfer       = !flush && sr_full && (!hold_full || pt_hs);

`ifdef TRIV_PACK_LSBFIRST_EN
  assign sr_next = {ks_bit, sr[W-1:1]};
`else
  assign sr_next = {sr[W-2:0], ks_bit};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr        <= '0;
      cnt       <= '0;
      hold_word <= '0;
      hold_full <= 1'b0;
      ovf       <= 1'b0;
    end else if (flush) begin
      sr        <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      if (bit_acc) begin
        sr <= sr_next;
      end
      // A transfer frees the shifter in the same cycle a new bit lands, so no bubble.
      if (xfer) begin
        hold_word <= sr;
        hold_full <= 1'b1;
        cnt       <= bit_acc ? CNT_ONE : '0;
      end else begin
        if (pt_hs) begin
          hold_full <= 1'b0;
        end
        if (bit_acc) begin
          cnt <= cnt + CNT_ONE;
        end
      end
      if (ks_vld && stall_core) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ct_data <= '0;
      ct_vld  <= 1'b0;
    end else if (pt_hs) begin
      ct_data <= pt_data ^ hold_word;
      ct_vld  <= 1'b1;
    end else if (ct_rdy) begin
      ct_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trivium_ks_packer.sv
// Directed and randomized bench for trivium_ks_packer against a queue-based word model.
module tb_trivium_ks_packer;

  localparam int W = 32;

`ifdef TRIV_PACK_LSBFIRST_EN
  localparam logic [W-1:0] EXP_BASIC = 32'h0F0F5A5A;
  localparam logic [W-1:0] EXP_FLUSH = 32'h1E6A2C48;
`else
  localparam logic [W-1:0] EXP_BASIC = 32'h5A5AF0F0;
  localparam logic [W-1:0] EXP_FLUSH = 32'h12345678;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         ks_bit = 1'b0;
  logic         ks_vld = 1'b0;
  logic         ks_stall;
  logic [W-1:0] pt_data = '0;
  logic         pt_vld = 1'b0;
  logic         pt_rdy;
  logic [W-1:0] ct_data;
  logic         ct_vld;
  logic         ct_rdy = 1'b0;
  logic         flush = 1'b0;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: pending keystream bits, held words, and the output register.
  bit           kq[$];
  logic [W-1:0] hq[$];
  logic [W-1:0] m_ct;
  logic         m_ctv;
  logic         m_ovf;
  logic         prev_pths;

  trivium_ks_packer #(.W(W)) dut (
    .CLK(CLK), .RST(RST),
    .ks_bit(ks_bit), .ks_vld(ks_vld), .ks_stall(ks_stall),
    .pt_data(pt_data), .pt_vld(pt_vld), .pt_rdy(pt_rdy),
    .ct_data(ct_data), .ct_vld(ct_vld), .ct_rdy(ct_rdy),
    .flush(flush), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    kq.delete();
    hq.delete();
    m_ct      = '0;
    m_ctv     = 1'b0;
    m_ovf     = 1'b0;
    prev_pths = 1'b0;
  endtask

  function automatic logic [W-1:0] pack_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
`ifdef TRIV_PACK_LSBFIRST_EN
      w[i] = kq[i];
`else
      w[W-1-i] = kq[i];
`endif
    end
    return w;
  endfunction

  // Called just after a falling edge: drive, check against the model, advance one cycle.
  task automatic step(input logic b, input logic v, input logic [W-1:0] p,
                      input logic pv, input logic cr, input logic fl);
    logic full, stall, prdy, pths, bacc;
    ks_bit = b; ks_vld = v; pt_data = p; pt_vld = pv; ct_rdy = cr; flush = fl;
    #1;
    full  = (kq.size() == W);
    stall = fl || (full && hq.size() == 1);
    prdy  = !fl && (hq.size() == 1) && (!m_ctv || cr);
    chk("ks_stall", 64'(ks_stall), 64'(stall));
    chk("pt_rdy",   64'(pt_rdy),   64'(prdy));
    chk("ct_vld",   64'(ct_vld),   64'(m_ctv));
    chk("ct_data",  64'(ct_data),  64'(m_ct));
    chk("ovf",      64'(ovf),      64'(m_ovf));
    pths = pv && prdy;
    bacc = v && !stall;
    if (pths) begin
      m_ct  = p ^ hq[0];
      m_ctv = 1'b1;
    end else if (cr) begin
      m_ctv = 1'b0;
    end
    if (fl) begin
      kq.delete();
      hq.delete();
    end else begin
      if (v && stall) m_ovf = 1'b1;
      if (pths) void'(hq.pop_front());
      if (full && hq.size() == 0) begin
        hq.push_back(pack_word());
        kq.delete();
      end
      if (bacc) kq.push_back(b);
    end
    prev_pths = pths;
    @(negedge CLK);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] p,
                           input logic pv, input logic cr, input logic gap);
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1, p, pv, cr, 1'b0);
      if (gap) step(1'b0, 1'b0, p, pv, cr, 1'b0);
    end
  endtask

  // Idle until ct_vld rises (bounded), then check the word and the one-cycle latency.
  task automatic wait_ct(input string tag, input logic [W-1:0] exp, input logic [W-1:0] p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (ct_vld) begin
        seen = 1'b1;
        chk({tag, "_lat"}, 64'(prev_pths), 64'(1));
        chk({tag, "_word"}, 64'(ct_data), 64'(exp));
      end else begin
        step(1'b0, 1'b0, p, 1'b1, 1'b1, 1'b0);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  initial begin
    logic [W-1:0] p;
    model_reset();
    @(negedge CLK);
    #1;
    chk("rst_ct_vld",   64'(ct_vld),   64'(0));
    chk("rst_ct_data",  64'(ct_data),  64'(0));
    chk("rst_ks_stall", 64'(ks_stall), 64'(0));
    chk("rst_pt_rdy",   64'(pt_rdy),   64'(0));
    chk("rst_ovf",      64'(ovf),      64'(0));
    @(negedge CLK);
    RST = 1'b0;

    // basic word, continuous bits
    send_word(32'hA5A50F0F, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    wait_ct("basic", EXP_BASIC, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // gapped bits
    send_word(32'hA5A50F0F, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
    wait_ct("gapped", EXP_BASIC, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // backpressure with three back-to-back words
    p = $urandom;
    send_word(32'h11111111, p, 1'b1, 1'b0, 1'b0);
    send_word(32'h22222222, p, 1'b1, 1'b0, 1'b0);
    send_word(32'h33333333, p, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0);
    chk("bp_stall", 64'(ks_stall), 64'(1));
    chk("bp_ct",    64'(ct_data),  64'(32'h11111111 ^ p));
    chk("bp_ovf",   64'(ovf),      64'(0));
    step(1'b0, 1'b0, p, 1'b1, 1'b1, 1'b0);
    chk("bp_ct2",    64'(ct_data),  64'(32'h22222222 ^ p));
    chk("bp_unstall", 64'(ks_stall), 64'(0));
    step(1'b0, 1'b0, p, 1'b1, 1'b1, 1'b0);
    chk("bp_ct3",   64'(ct_data),  64'(32'h33333333 ^ p));
    step(1'b0, 1'b0, p, 1'b1, 1'b0, 1'b0);

    // overflow: fill hold and shifter behind a blocked output, then push one more bit
    send_word($urandom, p, 1'b1, 1'b0, 1'b0);
    send_word($urandom, p, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, p, 1'b0, 1'b0, 1'b0);
    chk("ovf_pre", 64'(ovf), 64'(0));
    step(1'b1, 1'b1, p, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 64'(ovf), 64'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, p, 1'b0, 1'b0, 1'b0);
    chk("ovf_sticky", 64'(ovf), 64'(1));

    // flush with bits and pt presented in the flush cycle
    step(1'b1, 1'b1, p, 1'b1, 1'b0, 1'b1);
    chk("flush_ovf", 64'(ovf),    64'(1));
    chk("flush_ctv", 64'(ct_vld), 64'(1));
    step(1'b0, 1'b0, p, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'b1, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, '0, 1'b1, 1'b1, 1'b1);
    send_word(32'h12345678, '0, 1'b1, 1'b1, 1'b0);
    wait_ct("flush", EXP_FLUSH, '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset after 7 bits of a new word
    for (int i = 0; i < 7; i++) step(1'($urandom), 1'b1, '0, 1'b0, 1'b0, 1'b0);
    ks_vld = 1'b0; pt_vld = 1'b1; ct_rdy = 1'b1;
    #2 RST = 1'b1;
    #1;
    chk("arst_ct_vld",   64'(ct_vld),   64'(0));
    chk("arst_ct_data",  64'(ct_data),  64'(0));
    chk("arst_ovf",      64'(ovf),      64'(0));
    chk("arst_ks_stall", 64'(ks_stall), 64'(0));
    chk("arst_pt_rdy",   64'(pt_rdy),   64'(0));
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    send_word(32'hA5A50F0F, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
    wait_ct("post_rst", EXP_BASIC, 32'hFFFFFFFF);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom), ($urandom_range(0, 3) != 0), W'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trivium_ks_packer.md
Name: trivium_ks_packer

Overview:
- Downstream consumer of the Trivium core's serial keystream output (1 bit per cycle, qualified by the core's output-valid).
- Packs keystream bits into W-bit words and XORs each word with a plaintext/ciphertext word taken over a ready/valid handshake.
- Presents the result as a registered output word with its own ready/valid handshake.
- Drives a stall back to the core so no keystream bit is lost under output backpressure.

Parameters:
- W, 32, keystream/data word width in bits; legal range 2..64.
- CNT_W, derived localparam = clog2(W+1); not overridable.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ks_bit  in  1  keystream bit from the Trivium core.
- ks_vld  in  1  ks_bit valid this cycle.
- ks_stall  out  1  upstream must hold/stop producing bits while high; drives core EN low.
- pt_data  in  W  data word to encrypt/decrypt.
- pt_vld  in  1  pt_data valid.
- pt_rdy  out  1  pt word accepted this cycle when pt_vld && pt_rdy.
- ct_data  out  W  registered result word.
- ct_vld  out  1  ct_data valid.
- ct_rdy  in  1  downstream accepts ct_data when ct_vld && ct_rdy.
- flush  in  1  synchronous clear of partial and held keystream.
- ovf  out  1  sticky: a keystream bit arrived while ks_stall was high.

Behaviour:
- Reset (RST=1, asynchronous, any time including mid-word): shift reg=0, cnt=0, hold_word=0, hold_full=0, ct_data=0, ct_vld=0, ovf=0. Outputs: ks_stall=0, pt_rdy=0.
- Shifter:
  - Default order: first bit received ends in bit W-1. Each accepted bit performs sr <= {sr[W-2:0], ks_bit}, cnt++.
  - Bit accepted when ks_vld && !ks_stall.
- Word transfer: when cnt==W and (hold_full==0 or hold consumed this cycle):
  - hold_word <= sr, hold_full <= 1.
  - cnt <= 0, or cnt <= 1 if a bit is accepted the same cycle. No bubble.
- ks_stall = (cnt==W) && hold_full. Purely from registered state; no combinational path from pt_vld or ct_rdy.
- Illegal input: ks_vld while ks_stall=1 → bit dropped, ovf <= 1 (cleared only by RST).
- pt_rdy = hold_full && (!ct_vld || ct_rdy). This is combinational from ct_rdy.
- On pt handshake:
  - ct_data <= pt_data ^ hold_word, ct_vld <= 1.
  - hold_full <= 0 unless a transfer from the shifter refills it the same cycle.
- Latency: pt handshake in cycle N → ct_vld=1 in cycle N+1.
- Throughput: one word per W cycles of keystream; one pt/ct word per cycle when hold is refilled.
- ct_vld clears on ct handshake with no simultaneous pt handshake. ct_data is stable while ct_vld && !ct_rdy.
- flush=1:
  - Next edge: cnt=0, sr=0, hold_full=0.
  - ct_data/ct_vld unaffected.
  - Bits and pt words presented in the flush cycle are not accepted (pt_rdy forced 0 and ks_stall forced 1 during flush).
  - ovf unchanged.
- Simultaneous events:
  - Transfer and pt handshake in the same cycle: the handshake uses the old hold_word, and the new word is loaded.
  - ct handshake and pt handshake in the same cycle: the new ct is loaded and ct_vld stays 1.
- No data-dependent arithmetic; XOR only, full W width.

Optional Feature:
- Macro TRIV_PACK_LSBFIRST_EN.
- Defined: the first received bit lands in bit 0 (sr <= {ks_bit, sr[W-1:1]}). All other timing is identical.
- Undefined: MSB-first as above.

Test Plan:
- Reset: assert RST mid-word after 7 bits → all outputs 0 immediately; after release, a fresh 32 bits form a complete word (the 7 bits are discarded).
- Basic (W=32): stream 0xA5A50F0F MSB-first with ks_vld=1 every cycle, pt_data=0xFFFFFFFF, pt_vld=1, ct_rdy=1 → ct_data=0x5A5AF0F0, ct_vld high exactly one cycle after pt handshake.
- Gapped input: same word with ks_vld toggling 1/0 → identical ct_data 0x5A5AF0F0, produced after 63 cycles.
- Backpressure: ct_rdy=0, pt_vld=1, continuous bits for words 0x11111111, 0x22222222, 0x33333333 → ct holds 0x11111111^pt, hold=0x22222222, ks_stall=1 at cnt==32, ovf stays 0. Then ct_rdy=1 → words emerge in order and ks_stall drops the next cycle.
- Overflow/flush:
  - Push ks_vld while ks_stall=1 → ovf=1 and stays 1.
  - flush after 10 bits, then 0x12345678 with pt=0 → ct_data=0x12345678.
- Macro TRIV_PACK_LSBFIRST_EN defined: basic stream 0xA5A50F0F, pt=0xFFFFFFFF → ct_data=0x0F0F5A5A.
